// File: rtl/key_input_pkg.sv
// Shared definitions for the TTM4 key input port: key count, debounce states,
// default timing constants and the counter-width helper.
package key_input_pkg;

    localparam int NUM_KEYS            = 4;
    localparam int DEF_DEBOUNCE_MS     = 10;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_REPEAT_DELAY_MS = 500;
    localparam int DEF_REPEAT_MS       = 100;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } deb_state_t;

    // Bits needed to hold values 0..max_val, i.e. ceil(log2(max_val + 1)).
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) < (max_val + 1)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: synchroniser, tick-based debounce FSM and press-event pulse.
// KEY_INPUT_PORT_AUTO_REPEAT_EN adds a hold-time auto-repeat counter.
module key_debounce
    import key_input_pkg::*;
#(
    parameter int DEBOUNCE_MS     = DEF_DEBOUNCE_MS,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
    parameter int REPEAT_MS       = DEF_REPEAT_MS
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_key_n,
    output logic o_stable,
    output logic o_press
);

    localparam int CW = cnt_width(DEBOUNCE_MS);

    logic [SYNC_STAGES-1:0] r_sync;
    deb_state_t             r_state;
    deb_state_t             w_state_next;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_next;
    logic                   r_stable;
    logic                   w_stable_next;
    logic                   w_key;
    logic                   w_rise;
    logic                   w_repeat;

    assign w_key = ~r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync   <= '1;
            r_state  <= ST_STABLE;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_key_n};
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_stable <= w_stable_next;
        end
    end

    // The new level must be seen on DEBOUNCE_MS consecutive ticks to be accepted.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_stable_next = r_stable;
        if (i_tick) begin
            case (r_state)
                ST_STABLE: begin
                    if (w_key != r_stable) begin
                        if (DEBOUNCE_MS == 1) begin
                            w_stable_next = w_key;
                        end else begin
                            w_state_next = ST_PENDING;
                            w_cnt_next   = CW'(1);
                        end
                    end
                end
                ST_PENDING: begin
                    if (w_key == r_stable) begin
                        w_state_next = ST_STABLE;
                        w_cnt_next   = '0;
                    end else if (r_cnt == CW'(DEBOUNCE_MS - 1)) begin
                        w_stable_next = w_key;
                        w_state_next  = ST_STABLE;
                        w_cnt_next    = '0;
                    end else begin
                        w_cnt_next = r_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_next = ST_STABLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    assign w_rise = w_stable_next & ~r_stable;

`ifdef KEY_INPUT_PORT_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY_MS > REPEAT_MS) ? REPEAT_DELAY_MS : REPEAT_MS;
    localparam int RW   = cnt_width(RMAX);

    logic [RW-1:0] r_rep_cnt;
    logic          r_rep_first;

    assign w_repeat = r_stable & i_tick &
                      (r_rep_first ? (r_rep_cnt == RW'(REPEAT_DELAY_MS - 1))
                                   : (r_rep_cnt == RW'(REPEAT_MS - 1)));

    // First repeat after the long delay, then at the shorter interval.
    always_ff @(posedge i_clk) begin
        if (i_rst || !r_stable) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (i_tick) begin
            if (w_repeat) begin
                r_rep_cnt   <= '0;
                r_rep_first <= 1'b0;
            end else begin
                r_rep_cnt <= r_rep_cnt + RW'(1);
            end
        end
    end
`else
    localparam int unused_repeat_cfg = REPEAT_DELAY_MS + REPEAT_MS;
    assign w_repeat = 1'b0;
`endif

    assign o_stable = r_stable;
    assign o_press  = w_rise | w_repeat;

endmodule

// File: rtl/key_input_port.sv
// TTM4 key input port: debounced key levels and sticky press flags forming IR,
// cleared at the end of each upper-nibble read. Option: KEY_INPUT_PORT_AUTO_REPEAT_EN.
module key_input_port
    import key_input_pkg::*;
#(
    parameter int DEBOUNCE_MS     = DEF_DEBOUNCE_MS,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
    parameter int REPEAT_MS       = DEF_REPEAT_MS
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  TICK,
    input  logic [NUM_KEYS-1:0]   KEY_N,
    input  logic                  nIRU_OUT,
    input  logic                  nIRD_OUT,
    output logic [2*NUM_KEYS-1:0] IR,
    output logic                  EVENT
);

    logic [NUM_KEYS-1:0] w_stable;
    logic [NUM_KEYS-1:0] w_press;
    logic [NUM_KEYS-1:0] w_sticky_next;
    logic [NUM_KEYS-1:0] r_sticky;
    logic [NUM_KEYS-1:0] r_level;
    logic                r_event;
    logic                r_niru_q;
    logic                w_clear;
    logic                w_unused;

    assign w_unused = nIRD_OUT;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_MS    (DEBOUNCE_MS),
            .SYNC_STAGES    (SYNC_STAGES),
            .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
            .REPEAT_MS      (REPEAT_MS)
        ) u_debounce (
            .i_clk   (CLK),
            .i_rst   (RST),
            .i_tick  (TICK),
            .i_key_n (KEY_N[g]),
            .o_stable(w_stable[g]),
            .o_press (w_press[g])
        );
    end

    // Clear on the rising edge of the read strobe; a same-edge press still wins.
    assign w_clear       = nIRU_OUT & ~r_niru_q;
    assign w_sticky_next = (w_clear ? '0 : r_sticky) | w_press;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_niru_q <= 1'b1;
            r_sticky <= '0;
            r_level  <= '0;
            r_event  <= 1'b0;
        end else begin
            r_niru_q <= nIRU_OUT;
            r_sticky <= w_sticky_next;
            r_level  <= w_stable;
            r_event  <= |w_sticky_next;
        end
    end

    assign IR    = {r_sticky, r_level};
    assign EVENT = r_event;

endmodule

// File: doc/key_input_port.md
Name: key_input_port

Overview:
- Upstream input stage for the TTM4 CPU. It turns the four raw, active-low board keys into the 8-bit input register value `IR` that the register block drives onto LOADBUS.
- It synchronises and debounces each key against a 1 ms tick and latches sticky "pressed" events.
- Each read of the upper nibble by the CPU clears those event latches.

Parameters:
- DEBOUNCE_MS, 10: consecutive 1 ms ticks a synchronised key must hold a new level before its stable level changes (1..255).
- SYNC_STAGES, 2: flip-flop stages in the input synchroniser (>=2).
- REPEAT_DELAY_MS, 500: hold time before the first auto-repeat event (used only with the optional feature).
- REPEAT_MS, 100: interval between later auto-repeat events (used only with the optional feature).

Ports:
- CLK, input, 1: system clock (50 MHz).
- RST, input, 1: synchronous, active-high reset.
- TICK, input, 1: one-CLK-wide strobe every 1 ms.
- KEY_N, input, 4: raw keys, active-low, asynchronous.
- nIRU_OUT, input, 1: active-low read strobe for the upper IR nibble, from the decoder.
- nIRD_OUT, input, 1: active-low read strobe for the lower IR nibble, from the decoder.
- IR, output, 8: IR[7:4] are the sticky press flags; IR[3:0] are the debounced levels (1 = pressed).
- EVENT, output, 1: OR of IR[7:4].

Behaviour:
- Reset:
  - `RST` is synchronous and active-high; `CLK` is the only clock.
  - While `RST` is high, on every CLK edge: synchroniser flops load 1 (released), stable levels 0, debounce counters 0, sticky flags 0, read-edge register 1.
  - Outputs in reset: IR=8'h00, EVENT=0.
- Synchroniser: key_sync[i] = ~KEY_N[i] after SYNC_STAGES CLK edges.
- Debounce, per key, two states:
  - STABLE: counter=0. If key_sync differs from stable at a TICK, go to PENDING with counter=1.
  - PENDING:
    - At a TICK with key_sync still different from stable: counter+1.
    - When counter reaches DEBOUNCE_MS: stable toggles, counter=0, return to STABLE.
    - At a TICK with key_sync equal to stable: counter=0, return to STABLE (glitch rejected).
    - Without TICK, nothing changes.
- Press event: a stable 0->1 transition sets sticky[i] in the same CLK edge that updates stable. Release sets nothing.
- Read-clear:
  - Register nIRU_OUT once as nIRU_q.
  - Detect the rising edge: nIRU_OUT=1 while nIRU_q=0, i.e. the end of a read.
  - On that edge, clear all sticky flags. A read may span any number of cycles; the value seen during the read is what gets cleared.
- Simultaneous set and clear on the same edge: set wins for that key; the others clear.
- `nIRD_OUT` has no side effects. It is a port for completeness and future gating.
- Latency:
  - Raw edge to stable level: SYNC_STAGES CLK + DEBOUNCE_MS ticks (+ up to 1 tick of phase).
  - Stable level to IR: 1 CLK, registered.
  - IR and EVENT are registered outputs.
- Saturation and wrap:
  - Counters never exceed DEBOUNCE_MS.
  - Counter width is ceil(log2(max param + 1)).
- Reset mid-operation: a key held through reset is seen as released. It produces a fresh press event DEBOUNCE_MS ticks after RST falls.
- TICK during RST is ignored.

Optional Feature:
- Macro: KEY_INPUT_PORT_AUTO_REPEAT_EN.
- Defined:
  - Each key has a repeat counter that starts when stable goes to 1.
  - After REPEAT_DELAY_MS ticks held, sticky[i] is set again; then again every REPEAT_MS ticks while held.
  - The counter clears on release or RST.
  - A repeat set coinciding with read-clear follows the set-wins rule.
- Undefined: no repeat logic; a held key gives exactly one event per press.

Decomposition:
- Package key_input_pkg holds:
  - NUM_KEYS=4.
  - The debounce state enum {ST_STABLE, ST_PENDING}.
  - The counter-width function.
  - Default timing constants.
- One sub-module, key_debounce (synchroniser, debounce FSM and optional repeat counter for one key), instantiated NUM_KEYS times.
- The top level holds the sticky flags, read-edge detection and IR assembly.

Test Plan:
- Reset and idle: hold RST 3 cycles with KEY_N=4'hF -> IR=8'h00, EVENT=0, and they stay so for 50 ticks.
- Clean press: KEY_N[2]=0 held 20 ticks (DEBOUNCE_MS=10) -> IR becomes 8'h44 about 10 ticks after the edge, EVENT=1. Release -> IR=8'h40 after 10 ticks.
- Bounce rejection: KEY_N[0] toggles every 3 ticks for 30 ticks, then stays high -> IR stays 8'h00 and no event is set.
- Read-clear: with IR=8'h40, pulse nIRU_OUT low for 2 cycles -> IR[7:4] stays 4'h4 during the pulse and becomes 4'h0 one cycle after nIRU_OUT rises. A nIRD_OUT pulse leaves IR unchanged.
- Set/clear collision: align key1's debounce completion with the nIRU_OUT rising edge while sticky[3]=1 -> IR[7:4]=4'h2 afterwards.
- Auto-repeat (macro defined, 500/100): hold key0 for 800 ticks, clearing after each event -> events at about 10, 510, 610 and 710 ticks. With the macro undefined, only the first event occurs.
